// File: rtl/ad7908_adc_responder_if.sv
// AD7908 serial pin bundle between a converter-side initiator and the ADC-side responder.
// Latency: none, wires only.
// Backpressure: none; the initiator owns frame timing through ADC_CONVST/ADC_SCK.
// Signals: ADC_CONVST (frame select, active low), ADC_SCK (idles high),
//          ADC_SDI (control word, MSB first), ADC_SDO (result frame, MSB first).
interface ad7908_adc_responder_if;
    logic ADC_CONVST;
    logic ADC_SCK;
    logic ADC_SDI;
    logic ADC_SDO;

    modport master (
        output ADC_CONVST,
        output ADC_SCK,
        output ADC_SDI,
        input  ADC_SDO
    );

    modport slave (
        input  ADC_CONVST,
        input  ADC_SCK,
        input  ADC_SDI,
        output ADC_SDO
    );
endinterface

// File: rtl/ad7908_adc_responder.sv
// AD7908 ADC-side responder: decodes the 12-bit control word, shifts a 16-bit result frame.
// Latency: every pin event acts SYNC_STAGES+1 clk after the pin edge.
// Backpressure: none; SCK high/low phases must each last at least SYNC_STAGES+2 clk.
// Ports: clk, reset_n (async, active low), chan_data (channel k at [k*DATA_W +: DATA_W]),
//        adc (serial pins, slave side), ctrl_word/ctrl_valid (last written control word),
//        cur_chan (channel for the next frame), frame_done / frame_error (one-clk pulses).
module ad7908_adc_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_CH*DATA_W-1:0] chan_data,
    ad7908_adc_responder_if.slave    adc,
    output logic [11:0]              ctrl_word,
    output logic                     ctrl_valid,
    output logic [2:0]               cur_chan,
    output logic                     frame_done,
    output logic                     frame_error
);
    localparam int FRAME_W = DATA_W + 4;
    localparam int CTRL_W  = 12;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CTRL_BITS = CNT_W'(CTRL_W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Synchronizers plus one extra stage on CONVST/SCK for edge detection.
    logic [SYNC_STAGES-1:0] convst_sync, sck_sync, sdi_sync;
    logic                   convst_q, sck_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            convst_sync <= '1;
            sck_sync    <= '1;
            sdi_sync    <= '0;
            convst_q    <= 1'b1;
            sck_q       <= 1'b1;
        end else begin
            convst_sync <= {convst_sync[SYNC_STAGES-2:0], adc.ADC_CONVST};
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], adc.ADC_SCK};
            sdi_sync    <= {sdi_sync[SYNC_STAGES-2:0], adc.ADC_SDI};
            convst_q    <= convst_sync[SYNC_STAGES-1];
            sck_q       <= sck_sync[SYNC_STAGES-1];
        end
    end

    logic convst_s, sck_s, sdi_s;
    logic convst_fall, convst_rise, sck_fall;

    assign convst_s    = convst_sync[SYNC_STAGES-1];
    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync[SYNC_STAGES-1];
    assign convst_fall = convst_q & ~convst_s;
    assign convst_rise = ~convst_q & convst_s;
    assign sck_fall    = sck_q & ~sck_s;

    logic [DATA_W-1:0] ch_arr [NUM_CH];
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ch_arr[k] = chan_data[k*DATA_W +: DATA_W];
    end

    state_t             state;
    logic [CNT_W-1:0]   count;
    // Remaining frame bits below the current MSB; the leading zero is driven
    // directly at frame start so it never needs to be stored.
    logic [FRAME_W-2:0] shift_out;
    logic [CTRL_W-1:0]  shift_in;
    logic               sdo_r;

    assign adc.ADC_SDO = sdo_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            shift_out   <= '0;
            shift_in    <= '0;
            sdo_r       <= 1'b0;
            ctrl_word   <= '0;
            ctrl_valid  <= 1'b0;
            cur_chan    <= '0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            ctrl_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (convst_fall) begin
                        shift_out <= {cur_chan, ch_arr[cur_chan]};
                        sdo_r     <= 1'b0;
                        count     <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sck_fall) begin
                        if (count < CTRL_BITS) begin
                            shift_in <= {shift_in[CTRL_W-2:0], sdi_s};
                        end
                        shift_out <= {shift_out[FRAME_W-3:0], 1'b0};
                        count     <= count + 1'b1;
                        if (count == LAST_BIT) begin
                            // Final edge wins over a coincident CONVST rise.
                            sdo_r      <= 1'b0;
                            frame_done <= 1'b1;
                            if (shift_in[11]) begin
                                ctrl_word  <= shift_in;
                                ctrl_valid <= 1'b1;
                                cur_chan   <= shift_in[8:6];
                            end
                            state <= convst_rise ? IDLE : DONE;
                        end else if (convst_rise) begin
                            frame_error <= 1'b1;
                            sdo_r       <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            sdo_r <= shift_out[FRAME_W-2];
                        end
                    end else if (convst_rise) begin
                        frame_error <= 1'b1;
                        sdo_r       <= 1'b0;
                        state       <= IDLE;
                    end
                end
                DONE: begin
                    if (convst_rise) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
